// File: rtl/kerygma_mem_reqbuf_if.sv
// MemSplit32 bus: a request channel (req/ack with addr, we, wdata, be) and a
// read-response channel (resp pulse with rdata). There is no response for writes.
interface kerygma_mem_reqbuf_if;
    logic        req;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        ack;
    logic        resp;
    logic [31:0] rdata;

    modport master (output req, addr, we, wdata, be, input  ack, resp, rdata);
    modport slave  (input  req, addr, we, wdata, be, output ack, resp, rdata);
endinterface

// File: rtl/kerygma_mem_reqbuf.sv
// MemSplit32 request buffer: DEPTH-entry request FIFO, at most MAX_RD reads in flight, in-order responses.
// Define KERYGMA_MEMBUF_RESP_REG_EN to register the response path (+1 cycle on host.resp/host.rdata).
module kerygma_mem_reqbuf #(
    parameter int DEPTH  = 4,
    parameter int MAX_RD = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    kerygma_mem_reqbuf_if.slave  host,
    kerygma_mem_reqbuf_if.master mem,
    output logic                 err_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int RW = $clog2(MAX_RD + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [RW-1:0] RD_LIMIT = RW'(MAX_RD);

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  be;
    } entry_t;

    entry_t        fifo_q [DEPTH];
    entry_t        fifo_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [RW-1:0] rd_cnt_q, rd_cnt_d;
    logic          err_q, err_d;
    logic          full, empty, push, pop, rd_inc, rd_dec;
    entry_t        head;

    assign full  = (cnt_q == FULL_CNT);
    assign empty = (cnt_q == '0);
    // Acceptance looks only at local state so the upstream path never waits on downstream.
    assign host.ack = !full && (host.we || (rd_cnt_q < RD_LIMIT));
    assign push     = host.req && host.ack;
    assign pop      = mem.req && mem.ack;
    assign rd_inc   = push && !host.we;
    assign rd_dec   = mem.resp && (rd_cnt_q != '0);

    assign head      = fifo_q[rd_ptr_q];
    assign mem.req   = !empty;
    assign mem.addr  = head.addr;
    assign mem.we    = head.we;
    assign mem.wdata = head.wdata;
    assign mem.be    = head.be;
    assign err_o     = err_q;

    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        rd_cnt_d = rd_cnt_q;
        if (push) begin
            fifo_d[wr_ptr_q] = '{addr: host.addr, we: host.we, wdata: host.wdata, be: host.be};
            wr_ptr_d         = wr_ptr_q + 1'b1;
        end
        if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
        // A response arriving with nothing outstanding is flagged, never underflows the count.
        case ({rd_inc, rd_dec})
            2'b10:   rd_cnt_d = rd_cnt_q + 1'b1;
            2'b01:   rd_cnt_d = rd_cnt_q - 1'b1;
            default: rd_cnt_d = rd_cnt_q;
        endcase
        err_d = err_q || (mem.resp && (rd_cnt_q == '0));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            rd_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            rd_cnt_q <= rd_cnt_d;
            err_q    <= err_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk_i) begin
        fifo_q <= fifo_d;
    end

`ifdef KERYGMA_MEMBUF_RESP_REG_EN
    logic        resp_q, resp_d;
    logic [31:0] rdata_q, rdata_d;

    always_comb begin
        resp_d  = mem.resp;
        rdata_d = mem.resp ? mem.rdata : rdata_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            resp_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            resp_q  <= resp_d;
            rdata_q <= rdata_d;
        end
    end

    assign host.resp  = resp_q;
    assign host.rdata = rdata_q;
`else
    assign host.resp  = mem.resp;
    assign host.rdata = mem.rdata;
`endif
endmodule

// File: doc/kerygma_mem_reqbuf.md
# kerygma_mem_reqbuf

Request buffer between a tile's memory master (e.g. core instruction/data port) and the downstream memory slave, both on the MemSplit32 protocol. Decouples the two sides with a DEPTH-entry request FIFO, bounds outstanding reads to MAX_RD, and returns read responses in order. Sits directly downstream of the MemSplit32 master and upstream of the tile RAM or interconnect.

## Interface
- DEPTH, 4, request FIFO entries; power of two, ≥2
- MAX_RD, 4, maximum outstanding reads (accepted, response not yet seen); ≥1
- clk_i  in  1  clock
- rst_i  in  1  reset; asynchronous, active-high
- host  MemSplit32.Slave  if  upstream port: req/addr/we/wdata/be in, ack/resp/rdata out
- mem  MemSplit32.Master  if  downstream port: req/addr/we/wdata/be out, ack/resp/rdata in
- err_o  out  1  sticky: mem.resp seen with zero reads outstanding

## Operation
- Handshake: transfer on a port when req && ack in the same cycle. Writes get no response; each read gets exactly one resp pulse with rdata.
- FIFO entry = {addr, we, wdata, be} (69 bits). Push on host.req && host.ack; pop on mem.req && mem.ack.
- host.ack = !full && (host.we || rd_cnt < MAX_RD). ack never depends on mem signals.
- mem.req = !empty; mem.addr/we/wdata/be = FIFO head; head stable until popped.
- rd_cnt (width $clog2(MAX_RD+1)): +1 on accepted host read, −1 on mem.resp; both in same cycle → unchanged. Never exceeds MAX_RD.
- mem.resp with rd_cnt == 0: counter held at 0, err_o set; cleared only by rst_i.
- Push and pop in same cycle when not full: occupancy unchanged. When full ack=0, so no push; pop frees one slot, ack rises next cycle.
- Pointers wrap modulo DEPTH; full/empty from occupancy counter of width $clog2(DEPTH+1).
- Order strictly preserved: mem requests leave in host acceptance order; responses passed through in arrival order.

## Timing
- Reset values: mem.req=0, host.resp=0, host.rdata=0, err_o=0, FIFO empty, rd_cnt=0; host.ack=1 immediately after reset (combinational from empty state).
- Request latency: accepted at cycle N → earliest on mem.req at N+1 (no bypass).
- Throughput: one request per cycle each side in steady state.
- Response latency: see Configuration.
- Reset mid-operation: FIFO contents and rd_cnt discarded asynchronously; downstream must be reset together, else late responses set err_o.

## Configuration
- KERYGMA_MEMBUF_RESP_REG_EN defined: host.resp/host.rdata registered from mem.resp/mem.rdata, +1 cycle; rdata register loads only when mem.resp=1, holds otherwise.
- Undefined: host.resp = mem.resp, host.rdata = mem.rdata combinationally, zero latency.
- rd_cnt decrement and err_o timing identical in both builds (on mem.resp).

## Test plan
- Single write addr=0x100, wdata=0xDEADBEEF, be=0xF, mem.ack=1 → mem.req at N+1 with same fields, no host.resp, rd_cnt stays 0.
- Read addr=0x40, mem.resp with rdata=0x12345678 two cycles after issue → host.resp one pulse, rdata=0x12345678 (same cycle without macro, +1 with macro).
- mem.ack=0, host issues 5 writes back-to-back, DEPTH=4 → 4 acked, 5th held with ack=0; raise mem.ack → 4 pops in order, 5th acked cycle after first pop.
- MAX_RD=4, 5 reads, mem never responds → 4 accepted, host.ack=0 for 5th read while a write request still acks; one mem.resp → 5th read acked next cycle.
- mem.resp pulse with no reads outstanding → err_o=1 and stays 1 until rst_i.
- Assert rst_i with 3 entries queued and 2 reads outstanding → same cycle mem.req=0, host.resp=0, ack=1 after deassert, err_o=0.
